mp_alu_seq: RTL and testbench
=============================

Name: mp_alu_seq

Overview:
- Multi-precision arithmetic sequencer placed directly upstream of the N-bit `alu`.
- Latches two W-word operands, feeds the ALU one N-bit word per cycle (LS word first) and chains the carry between words.
- Collects the result words and reports final unsigned-overflow/borrow, signed-overflow and zero flags.
- Lets the existing ripple ALU run 16/32/64-bit operations without widening it.

Parameters:
- N, 8, ALU word width in bits; passed to the `alu` instance.
- W, 4, number of words per operand; W >= 1.

Ports:
- clk  input  1  clock; all state updates on rising edge.
- rst  input  1  synchronous, active-high reset.
- start  input  1  request; accepted only in IDLE.
- op_f  input  2  ALU function code; 00 = add, others are bitwise ops.
- op_comp  input  1  complement b (subtract when op_f=00 and op_ci=1).
- op_ci  input  1  carry-in to the least-significant word.
- a_in  input  N*W  operand A; sampled on the accept cycle.
- b_in  input  N*W  operand B; sampled on the accept cycle.
- busy  output  1  high from the cycle after accept until done.
- done  output  1  one-cycle pulse; result and flags valid from this cycle.
- result  output  N*W  full-width result; held until the next accept or reset.
- uo_out  output  1  unsigned carry-out (add) or borrow (subtract).
- so_out  output  1  signed overflow of the full-width operation.
- zero_out  output  1  result == 0 (see Optional Feature).

Behaviour:
- Clock/reset: one clock, clk. Reset is synchronous and active-high (rst).
- Reset values: busy, done, result, uo_out, so_out and zero_out all 0; state IDLE; word index 0.
- FSM states IDLE, RUN, DONE.
- IDLE, start=1: latch a_in, b_in, op_f, op_comp, op_ci; word index k=0; chain carry cy=op_ci; go to RUN.
- RUN, cycle k: ALU receives a=A[k*N +: N], b=B[k*N +: N], ci=cy, comp=op_comp, f=op_f.
  - ALU q is written into result[k*N +: N] at the clock edge.
  - Raw word carry rc = ALU uo XOR (op_comp & cy & (op_f==00)). This undoes the ALU's per-word borrow correction.
  - cy <= rc.
  - When k == W-1: capture uo_out, so_out and zero_out (see below), then go to DONE. Otherwise k <= k+1.
- Flags, captured on the top word (k = W-1):
  - uo_out = rc XOR (op_comp & op_ci & (op_f==00)), so borrow semantics match a single-word ALU operation.
  - so_out = ALU so of the top word.
  - zero_out = 1 when all W result words are 0.
- DONE: done=1 for exactly one cycle, then return to IDLE. busy=1 in RUN and DONE only.
- Latency: accept edge to done asserted = W+1 cycles. Back-to-back accept is allowed in the cycle after DONE.
- start while busy: ignored, no queuing.
- result, uo_out and so_out keep their previous values until the next accepted op overwrites them word by word.
  - During RUN, result is partially updated; consumers must qualify with done.
- op_f != 00: carry still chains through the ALU as-is. Flags are computed by the same rules; only zero_out is meaningful.
- W=1: RUN lasts one cycle; behaviour equals a single ALU operation plus registering.
- rst during RUN or DONE: immediate return to IDLE with reset values; no done pulse.

Optional Feature:
- Macro MP_ALU_SEQ_ZFLAG_EN.
- Defined: zero_out is computed as a running OR of result words across RUN. It is registered with the other flags.
- Undefined: zero_out is tied to 0 and no zero logic is built.

Decomposition:
- Shared package `mp_alu_pkg`:
  - function-code constants F_ADD=2'b00, F_OP1=2'b01, F_OP2=2'b10, F_OP3=2'b11;
  - state encoding IDLE=2'd0, RUN=2'd1, DONE=2'd2.
- One natural sub-module: the existing `alu` (N-bit), instantiated once. All sequencing stays in mp_alu_seq.

Test Plan:
- N=8, W=4, add 0x000000FF + 0x00000001, ci=0 -> done 5 cycles after accept; result 0x00000100; uo=0, so=0, zero=0.
- Subtract (op_comp=1, op_ci=1, op_f=00) 0x00000000 - 0x00000001 -> result 0xFFFFFFFF, uo=1 (borrow), so=0.
- Subtract 0x00001234 - 0x00000234 -> result 0x00001000, uo=0, so=0.
- Add 0x7FFFFFFF + 0x00000001 -> result 0x80000000, so=1, uo=0.
- Add 0xFFFFFFFF + 0x00000001 -> result 0x00000000, uo=1, zero=1 with macro defined, 0 without.
- Accept op, pulse start again at cycle 2 -> ignored, single done. Then start new op, assert rst at cycle 2 -> busy=0 next cycle, result=0, no done pulse.

Source files
------------

// File: rtl/mp_alu_seq_pkg.sv
// Shared definitions for the multi-precision ALU sequencer:
// ALU function codes and the sequencer state encoding.
package mp_alu_pkg;

    localparam logic [1:0] F_ADD = 2'b00;
    localparam logic [1:0] F_OP1 = 2'b01;
    localparam logic [1:0] F_OP2 = 2'b10;
    localparam logic [1:0] F_OP3 = 2'b11;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

endpackage

// File: rtl/mp_alu_seq_if.sv
// Request/result bundle of the multi-precision ALU sequencer.
//
// Handshake: start is a request that is taken only while the sequencer is
// idle (busy=0); the operands and op fields are sampled on that same edge.
// A start seen while busy=1 is dropped, nothing is queued. done is a
// one-cycle pulse; result and the flags are valid from that cycle and stay
// put until the next accepted request starts overwriting them.
interface mp_alu_seq_if #(
    parameter int N = 8,
    parameter int W = 4
) ();
    logic           start;
    logic [1:0]     op_f;
    logic           op_comp;
    logic           op_ci;
    logic [N*W-1:0] a_in;
    logic [N*W-1:0] b_in;
    logic           busy;
    logic           done;
    logic [N*W-1:0] result;
    logic           uo_out;
    logic           so_out;
    logic           zero_out;

    modport master (
        output start, op_f, op_comp, op_ci, a_in, b_in,
        input  busy, done, result, uo_out, so_out, zero_out
    );

    modport slave (
        input  start, op_f, op_comp, op_ci, a_in, b_in,
        output busy, done, result, uo_out, so_out, zero_out
    );
endinterface

// File: rtl/mp_alu_seq_alu.sv
// N-bit combinational ALU. f=00 adds a + (comp ? ~b : b) + ci; the other
// codes are bitwise AND/OR/XOR against the (optionally complemented) b.
// On add, uo reports carry, or borrow when subtracting (comp & ci), so a
// single word behaves like a conventional subtractor.
module alu
    import mp_alu_pkg::*;
#(
    parameter int N = 8
) (
    input  logic [N-1:0] a,
    input  logic [N-1:0] b,
    input  logic         ci,
    input  logic         comp,
    input  logic [1:0]   f,
    output logic [N-1:0] q,
    output logic         uo,
    output logic         so
);
    logic [N-1:0] bx;
    logic [N:0]   sum;

    // Word arithmetic/logic and flag generation.
    always_comb begin
        bx  = comp ? ~b : b;
        sum = {1'b0, a} + {1'b0, bx} + {{N{1'b0}}, ci};
        q   = '0;
        uo  = 1'b0;
        so  = 1'b0;
        case (f)
            F_ADD: begin
                q  = sum[N-1:0];
                uo = sum[N] ^ (comp & ci);
                so = (a[N-1] == bx[N-1]) && (sum[N-1] != a[N-1]);
            end
            F_OP1:   q = a & bx;
            F_OP2:   q = a | bx;
            F_OP3:   q = a ^ bx;
            default: q = '0;
        endcase
    end
endmodule

// File: rtl/mp_alu_seq.sv
// Multi-precision sequencer in front of the N-bit ALU: runs a W-word
// operation one word per cycle, least-significant word first, chaining the
// raw carry between words, then reports carry/borrow, signed overflow and
// zero for the full width.
// Optional: MP_ALU_SEQ_ZFLAG_EN builds the zero flag; without it zero_out=0.
module mp_alu_seq
    import mp_alu_pkg::*;
#(
    parameter int N = 8,
    parameter int W = 4
) (
    input  logic              clk,
    input  logic              rst,
    mp_alu_seq_if.slave       bus,
    output state_t            dbg_state
);
    localparam int KW = (W > 1) ? $clog2(W) : 1;

    state_t         state, state_nxt;
    logic [KW-1:0]  k;
    logic           cy;
    logic [N*W-1:0] a_r, b_r;
    logic [1:0]     f_r;
    logic           comp_r, ci_r;
    logic [N*W-1:0] result_r;
    logic           uo_r, so_r;

    logic           accept, last;
    logic [N-1:0]   alu_q;
    logic           alu_uo, alu_so, rc, is_add;

    assign accept = (state == IDLE) && bus.start;
    assign last   = (k == KW'(W - 1));
    assign is_add = (f_r == F_ADD);

    alu #(.N(N)) u_alu (
        .a    (a_r[int'(k)*N +: N]),
        .b    (b_r[int'(k)*N +: N]),
        .ci   (cy),
        .comp (comp_r),
        .f    (f_r),
        .q    (alu_q),
        .uo   (alu_uo),
        .so   (alu_so)
    );

    // The ALU folds borrow inversion into uo on subtract; undo it so the
    // true carry propagates between words.
    assign rc = alu_uo ^ (comp_r & cy & is_add);

    // State register.
    always_ff @(posedge clk) begin
        if (rst) state <= IDLE;
        else     state <= state_nxt;
    end

    // Next-state: one RUN cycle per word, then a single DONE cycle.
    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (bus.start) state_nxt = RUN;
            RUN:     if (last)      state_nxt = DONE;
            DONE:    state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    // Operand latch, word walk, result assembly and flag capture.
    always_ff @(posedge clk) begin
        if (rst) begin
            k        <= '0;
            cy       <= 1'b0;
            a_r      <= '0;
            b_r      <= '0;
            f_r      <= F_ADD;
            comp_r   <= 1'b0;
            ci_r     <= 1'b0;
            result_r <= '0;
            uo_r     <= 1'b0;
            so_r     <= 1'b0;
        end else if (accept) begin
            a_r    <= bus.a_in;
            b_r    <= bus.b_in;
            f_r    <= bus.op_f;
            comp_r <= bus.op_comp;
            ci_r   <= bus.op_ci;
            k      <= '0;
            cy     <= bus.op_ci;
        end else if (state == RUN) begin
            result_r[int'(k)*N +: N] <= alu_q;
            cy <= rc;
            if (last) begin
                // Re-apply the borrow convention once, for the whole width.
                uo_r <= rc ^ (comp_r & ci_r & is_add);
                so_r <= alu_so;
                k    <= '0;
            end else begin
                k <= k + KW'(1);
            end
        end
    end

`ifdef MP_ALU_SEQ_ZFLAG_EN
    logic z_acc, z_any, zero_r;
    assign z_any = ((k == '0) ? 1'b0 : z_acc) | (|alu_q);

    // Running OR of result words; registered as zero on the top word.
    always_ff @(posedge clk) begin
        if (rst) begin
            z_acc  <= 1'b0;
            zero_r <= 1'b0;
        end else if (state == RUN) begin
            z_acc <= z_any;
            if (last) zero_r <= ~z_any;
        end
    end
    assign bus.zero_out = zero_r;
`else
    assign bus.zero_out = 1'b0;
`endif

    assign bus.busy   = (state != IDLE);
    assign bus.done   = (state == DONE);
    assign bus.result = result_r;
    assign bus.uo_out = uo_r;
    assign bus.so_out = so_r;
    assign dbg_state  = state;
endmodule

// File: tb/tb_mp_alu_seq.sv
// Bench for mp_alu_seq (N=8, W=4): directed and random operations checked
// against a full-width arithmetic reference model.
module tb_mp_alu_seq;
    import mp_alu_pkg::*;

    localparam int N  = 8;
    localparam int W  = 4;
    localparam int TW = N * W;

    logic   clk;
    logic   rst;
    state_t dbg_state;
    int     pass_cnt;
    int     total_cnt;
    logic [TW-1:0] exp_q[$];

    mp_alu_seq_if #(.N(N), .W(W)) bus_if ();

    mp_alu_seq #(.N(N), .W(W)) dut (
        .clk       (clk),
        .rst       (rst),
        .bus       (bus_if),
        .dbg_state (dbg_state)
    );

    // Clock / reset
    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] expv);
        total_cnt++;
        assert (obs === expv) pass_cnt++;
        else $error("FAIL %s: observed %0h expected %0h", tag, obs, expv);
    endtask

    // Reference: whole-width arithmetic, no word slicing.
    function automatic void ref_model(
        input  logic [TW-1:0] a, input logic [TW-1:0] b,
        input  logic [1:0] f, input logic comp, input logic ci,
        output logic [TW-1:0] r, output logic uo, output logic so, output logic z);
        logic [TW-1:0] bx;
        logic [TW:0]   s;
        bx = comp ? ~b : b;
        s  = {1'b0, a} + {1'b0, bx} + {{TW{1'b0}}, ci};
        uo = 1'b0;
        so = 1'b0;
        case (f)
            2'b00: begin
                r  = s[TW-1:0];
                uo = s[TW] ^ (comp & ci);
                so = (a[TW-1] == bx[TW-1]) && (r[TW-1] != a[TW-1]);
            end
            2'b01:   r = a & bx;
            2'b10:   r = a | bx;
            default: r = a ^ bx;
        endcase
`ifdef MP_ALU_SEQ_ZFLAG_EN
        z = (r == '0);
`else
        z = 1'b0;
`endif
    endfunction

    // Driver: called at a negedge; issues one op and checks its completion.
    task automatic run_op(input string nm, input logic [TW-1:0] a, input logic [TW-1:0] b,
                          input logic [1:0] f, input logic comp, input logic ci);
        logic [TW-1:0] er, got;
        logic euo, eso, ez;
        int cyc;
        ref_model(a, b, f, comp, ci, er, euo, eso, ez);
        exp_q.push_back(er);
        bus_if.a_in    = a;
        bus_if.b_in    = b;
        bus_if.op_f    = f;
        bus_if.op_comp = comp;
        bus_if.op_ci   = ci;
        bus_if.start   = 1'b1;
        @(negedge clk);
        bus_if.start = 1'b0;
        cyc = 1;
        check({nm, " busy"}, 64'(bus_if.busy), 64'd1);
        while (!bus_if.done && cyc < 20) begin
            @(negedge clk);
            cyc++;
        end
        check({nm, " latency"}, 64'(cyc), 64'(W + 1));
        got = exp_q.pop_front();
        check({nm, " result"}, 64'(bus_if.result), 64'(got));
        if (f == 2'b00) begin
            check({nm, " uo"}, 64'(bus_if.uo_out), 64'(euo));
            check({nm, " so"}, 64'(bus_if.so_out), 64'(eso));
        end
        check({nm, " zero"}, 64'(bus_if.zero_out), 64'(ez));
        @(negedge clk);
        check({nm, " done pulse"}, 64'(bus_if.done), 64'd0);
        check({nm, " idle"}, 64'(bus_if.busy), 64'd0);
    endtask

    initial begin
        logic [TW-1:0] ra, rb, er;
        logic euo, eso, ez;
        logic [1:0] rf;
        int ndone;
        pass_cnt  = 0;
        total_cnt = 0;
        rst            = 1'b1;
        bus_if.start   = 1'b0;
        bus_if.a_in    = '0;
        bus_if.b_in    = '0;
        bus_if.op_f    = 2'b00;
        bus_if.op_comp = 1'b0;
        bus_if.op_ci   = 1'b0;
        repeat (3) @(negedge clk);

        check("rst busy",   64'(bus_if.busy),     64'd0);
        check("rst done",   64'(bus_if.done),     64'd0);
        check("rst result", 64'(bus_if.result),   64'd0);
        check("rst uo",     64'(bus_if.uo_out),   64'd0);
        check("rst so",     64'(bus_if.so_out),   64'd0);
        check("rst zero",   64'(bus_if.zero_out), 64'd0);
        check("rst state",  64'(dbg_state),       64'(IDLE));
        rst = 1'b0;
        @(negedge clk);

        // Directed cases
        run_op("add_ff_1",   32'h000000FF, 32'h00000001, 2'b00, 1'b0, 1'b0);
        check("add_ff_1 value", 64'(bus_if.result), 64'h100);
        run_op("sub_0_1",    32'h00000000, 32'h00000001, 2'b00, 1'b1, 1'b1);
        check("sub_0_1 borrow", 64'(bus_if.uo_out), 64'd1);
        run_op("sub_1234",   32'h00001234, 32'h00000234, 2'b00, 1'b1, 1'b1);
        check("sub_1234 value", 64'(bus_if.result), 64'h1000);
        run_op("add_7fff",   32'h7FFFFFFF, 32'h00000001, 2'b00, 1'b0, 1'b0);
        check("add_7fff so", 64'(bus_if.so_out), 64'd1);
        run_op("add_ffff",   32'hFFFFFFFF, 32'h00000001, 2'b00, 1'b0, 1'b0);
        check("add_ffff value", 64'(bus_if.result), 64'h0);
        run_op("and_op",     32'hF0F0A5A5, 32'h0F0F5A5A, 2'b01, 1'b0, 1'b0);
        run_op("xor_cmp",    32'h12345678, 32'h12345678, 2'b11, 1'b1, 1'b0);

        // Start while busy is ignored: one done, original operands used.
        ref_model(32'h00010203, 32'h01010101, 2'b00, 1'b0, 1'b0, er, euo, eso, ez);
        bus_if.a_in  = 32'h00010203;
        bus_if.b_in  = 32'h01010101;
        bus_if.op_f  = 2'b00; bus_if.op_comp = 1'b0; bus_if.op_ci = 1'b0;
        bus_if.start = 1'b1;
        @(negedge clk);
        bus_if.start = 1'b0;
        @(negedge clk);
        bus_if.a_in  = 32'hDEADBEEF;
        bus_if.start = 1'b1;
        @(negedge clk);
        bus_if.start = 1'b0;
        ndone = 0;
        for (int i = 0; i < 12; i++) begin
            if (bus_if.done) begin
                ndone++;
                check("ignore result", 64'(bus_if.result), 64'(er));
            end
            @(negedge clk);
        end
        check("ignore single done", 64'(ndone), 64'd1);

        // Reset in the middle of RUN.
        bus_if.a_in  = 32'h11111111;
        bus_if.b_in  = 32'h22222222;
        bus_if.start = 1'b1;
        @(negedge clk);
        bus_if.start = 1'b0;
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        check("midrst busy",   64'(bus_if.busy),     64'd0);
        check("midrst result", 64'(bus_if.result),   64'd0);
        check("midrst uo",     64'(bus_if.uo_out),   64'd0);
        check("midrst state",  64'(dbg_state),       64'(IDLE));
        rst = 1'b0;
        ndone = 0;
        for (int i = 0; i < 10; i++) begin
            if (bus_if.done) ndone++;
            @(negedge clk);
        end
        check("midrst no done", 64'(ndone), 64'd0);

        // Random operations, back to back; biased toward add/subtract.
        for (int i = 0; i < 40; i++) begin
            case ($urandom_range(0, 5))
                0:       ra = 32'hFFFFFFFF;
                1:       ra = 32'h7FFFFFFF;
                default: ra = $urandom;
            endcase
            case ($urandom_range(0, 5))
                0:       rb = 32'h00000001;
                1:       rb = 32'h80000000;
                2:       rb = ra;
                default: rb = $urandom;
            endcase
            rf = ($urandom_range(0, 3) == 0) ? 2'($urandom_range(1, 3)) : 2'b00;
            if ($urandom_range(0, 1) == 1)
                run_op($sformatf("rnd%0d_sub", i), ra, rb, rf, 1'b1, 1'b1);
            else
                run_op($sformatf("rnd%0d", i), ra, rb, rf, 1'b0, 1'($urandom_range(0, 1)));
        end

        $display("%0d/%0d checks passed", pass_cnt, total_cnt);
        $finish;
    end
endmodule
